time_datapath: RTL and testbench
================================

Name: time_datapath

Overview:
Datapath responder for the stopwatch/timer control FSM. It consumes the FSM's clear/enable/increment/decrement/write/read/output_select strobes and returns the time-up flag. Holds a 4-digit BCD MM:SS counter with a 1 Hz prescaler, a last-time capture register and a registered display mux feeding the seven-segment driver.

Parameters:
TICK_DIV, 10000000, clk cycles per one-second tick (>= 2)
TICK_W, 24, prescaler width; must satisfy 2**TICK_W >= TICK_DIV

Ports:
clk  in  1  system clock
nrst  in  1  reset nrst, asynchronous, active-low
clear  in  1  level; zero counter, prescaler, flag
enable  in  1  level; stopwatch count-up
enable_increment  in  1  level; timer set mode
inc_pulse  in  1  single-cycle synchronized button pulse; +1 s in set mode
enable_decrement  in  1  level; timer count-down
write  in  1  single-cycle; capture counter into last-time register
read  in  1  level; force display of last-time register
output_select  in  2  display source select
flag  out  1  sticky time-up indication to FSM
tick  out  1  one-cycle one-second strobe (debug/LED)
disp  out  16  BCD {min_tens, min_ones, sec_tens, sec_ones}

Behaviour:
- Reset: count=0000, last=0000, prescaler=0, flag=0, tick=0, disp=0000.
- Prescaler (tick_gen): counts only while enable or enable_decrement (and not clear, not enable_increment); at TICK_DIV-1 wraps to 0 and asserts tick for exactly that one cycle; held at 0 otherwise, so first tick arrives TICK_DIV cycles after run starts.
- Counter update priority per cycle: clear > enable_increment > enable > enable_decrement > hold.
- clear: count<=0000, prescaler<=0, flag<=0. write in same cycle captures pre-clear count.
- enable_increment & inc_pulse: count +1 s. No tick used.
- enable & tick: count +1 s.
- enable_decrement & tick & count!=0000: count -1 s; if result is 0000, flag<=1 in the same edge.
- enable_decrement & count==0000: flag<=1 next edge, no tick needed; count stays 0000 (no underflow).
- +1 s BCD: sec_ones 9->0 carry; sec_tens 5->0 carry; min_ones 9->0 carry; min_tens 5->0; 59:59 wraps to 00:00.
- -1 s BCD: mirror borrows; seconds 00 -> 59 with minute borrow; never applied at 00:00.
- All digits always legal BCD (sec_tens, min_tens <= 5).
- flag: sticky; cleared only by clear or reset.
- write: last<=count (value before this edge's update).
- Display (registered, 1-cycle latency): read=1 -> last; else output_select 00 -> 0000, 01 -> count, 10 -> last, 11 -> count.
- Simultaneous enable and enable_decrement: enable wins (count up). inc_pulse outside set mode ignored.
- nrst assertion mid-run: immediate return to reset values; no residual tick.

Decomposition:
- Package time_pkg: bcd_time_t packed struct (min_t, min_o, sec_t, sec_o, 4 bits each), TIME_ZERO constant, functions bcd_inc_sec and bcd_dec_sec (pure combinational).
- Sub-module tick_gen (TICK_DIV, TICK_W): run, clr in; tick out. Top instantiates one.

Test Plan:
- TICK_DIV=4; reset, enable=1 for 40 cycles, output_select=01 -> ticks every 4 cycles, disp 0000->0010 (00:10), flag=0.
- Preload 00:59 via inc_pulse x59 in set mode, then enable for one tick -> disp 0100; from 59:59 one tick -> 0000.
- Set 00:03 via 3 inc_pulses, enable_decrement -> 0002,0001,0000 at 4-cycle spacing, flag rises on 0000 edge and stays high; clear -> flag 0, disp 0000.
- enable_decrement with count 0000 -> flag=1 one cycle later, count stays 0000, no underflow to 5959.
- Run to 00:07, write pulse, clear, read=1 -> disp 0007 while counter is 0000; output_select=10 same; 00 -> 0000.
- Assert nrst low mid-countdown at 00:02 -> all outputs 0 asynchronously; after release no tick until 4 run cycles elapse.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types and BCD arithmetic for the MM:SS time datapath.
package time_pkg;

  // Four BCD digits of a minutes:seconds value.
  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

  // Add one second; 59:59 wraps to 00:00.
  function automatic bcd_time_t bcd_inc_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_o != 4'd9) begin
      r.sec_o = t.sec_o + 4'd1;
    end else begin
      r.sec_o = 4'd0;
      if (t.sec_t != 4'd5) begin
        r.sec_t = t.sec_t + 4'd1;
      end else begin
        r.sec_t = 4'd0;
        if (t.min_o != 4'd9) begin
          r.min_o = t.min_o + 4'd1;
        end else begin
          r.min_o = 4'd0;
          r.min_t = (t.min_t == 4'd5) ? 4'd0 : t.min_t + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Subtract one second; the caller never applies this at 00:00.
  function automatic bcd_time_t bcd_dec_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_o != 4'd0) begin
      r.sec_o = t.sec_o - 4'd1;
    end else begin
      r.sec_o = 4'd9;
      if (t.sec_t != 4'd0) begin
        r.sec_t = t.sec_t - 4'd1;
      end else begin
        r.sec_t = 4'd5;
        if (t.min_o != 4'd0) begin
          r.min_o = t.min_o - 4'd1;
        end else begin
          r.min_o = 4'd9;
          r.min_t = (t.min_t == 4'd0) ? 4'd5 : t.min_t - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/time_datapath_tick_gen.sv
// One-second prescaler: counts while run is high, strobes tick on the last count.
module tick_gen #(
  parameter int TICK_DIV = 10000000,
  parameter int TICK_W   = 24
) (
  input  logic clk,
  input  logic nrst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] cnt;

  // Prescaler register: held at zero unless running, wraps at the last count.
  // NOTE: state in always_ff uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Strobe for the single cycle spent on the last count.
  assign tick = run && !clr && (cnt == LAST);

endmodule

// File: rtl/time_datapath.sv
// BCD MM:SS stopwatch/timer datapath with last-time capture and registered display.
module time_datapath
  import time_pkg::*;
#(
  parameter int TICK_DIV = 10000000,
  parameter int TICK_W   = 24
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  input  logic        enable,
  input  logic        enable_increment,
  input  logic        inc_pulse,
  input  logic        enable_decrement,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  output_select,
  output logic        flag,
  output logic        tick,
  output logic [15:0] disp
);

  bcd_time_t count;
  bcd_time_t last;
  bcd_time_t count_inc;
  bcd_time_t count_dec;
  logic      run;
  logic [15:0] disp_next;

  // Prescaler only runs in a counting mode; set mode and clear hold it at zero.
  assign run = (enable || enable_decrement) && !clear && !enable_increment;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_tick_gen (
    .clk  (clk),
    .nrst (nrst),
    .run  (run),
    .clr  (clear),
    .tick (tick)
  );

  assign count_inc = bcd_inc_sec(count);
  assign count_dec = bcd_dec_sec(count);

  // Counter and sticky flag, priority clear > set > count-up > count-down.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= TIME_ZERO;
      flag  <= 1'b0;
    end else if (clear) begin
      count <= TIME_ZERO;
      flag  <= 1'b0;
    end else if (enable_increment) begin
      if (inc_pulse) count <= count_inc;
    end else if (enable) begin
      if (tick) count <= count_inc;
    end else if (enable_decrement) begin
      if (count == TIME_ZERO) begin
        flag <= 1'b1;
      end else if (tick) begin
        count <= count_dec;
        if (count_dec == TIME_ZERO) flag <= 1'b1;
      end
    end
  end

  // Last-time capture takes the value before this edge's counter update.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last <= TIME_ZERO;
    end else if (write) begin
      last <= count;
    end
  end

  // Display source select; read overrides output_select.
  // NOTE: disp_next gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    disp_next = 16'h0000;
    if (read) begin
      disp_next = last;
    end else begin
      case (output_select)
        2'b01:   disp_next = count;
        2'b10:   disp_next = last;
        2'b11:   disp_next = count;
        default: disp_next = 16'h0000;
      endcase
    end
  end

  // Registered display output, one cycle behind the selected source.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      disp <= 16'h0000;
    end else begin
      disp <= disp_next;
    end
  end

endmodule

// File: tb/tb_time_datapath.sv
// Directed self-checking bench for time_datapath with a 4-cycle tick.
module tb_time_datapath;

  logic        clk = 1'b0;
  logic        nrst;
  logic        clear, enable, enable_increment, inc_pulse, enable_decrement;
  logic        write, read;
  logic [1:0]  output_select;
  logic        flag, tick;
  logic [15:0] disp;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        rd;
    logic [1:0]  sel;
    logic [15:0] exp_disp;
  } disp_vec_t;

  disp_vec_t vecs [7];

  time_datapath #(.TICK_DIV(4), .TICK_W(3)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .clear            (clear),
    .enable           (enable),
    .enable_increment (enable_increment),
    .inc_pulse        (inc_pulse),
    .enable_decrement (enable_decrement),
    .write            (write),
    .read             (read),
    .output_select    (output_select),
    .flag             (flag),
    .tick             (tick),
    .disp             (disp)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Advance n clock edges, then settle 1 ns past the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  // Load n seconds in set mode with inc_pulse held each cycle.
  task automatic set_secs(input int n);
    enable_increment = 1'b1;
    inc_pulse = 1'b1;
    cyc(n);
    inc_pulse = 1'b0;
    enable_increment = 1'b0;
  endtask

  initial begin
    int ticks;
    int first_tick;

    nrst = 1'b0;
    {clear, enable, enable_increment, inc_pulse, enable_decrement, write, read} = '0;
    output_select = 2'b00;
    cyc(2);
    check("reset_flag", {15'd0, flag}, 16'h0);
    check("reset_tick", {15'd0, tick}, 16'h0);
    check("reset_disp", disp, 16'h0000);
    nrst = 1'b1;
    cyc(1);

    // Count up for 40 cycles: 10 ticks, first one in the 4th run cycle.
    output_select = 2'b01;
    enable = 1'b1;
    ticks = 0;
    first_tick = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    enable = 1'b0;
    cyc(1);
    check("up_tick_count", 16'(ticks), 16'd10);
    check("up_first_tick", 16'(first_tick), 16'd3);
    check("up_disp_0010", disp, 16'h0010);
    check("up_flag", {15'd0, flag}, 16'h0);

    // inc_pulse outside set mode is ignored.
    inc_pulse = 1'b1;
    cyc(3);
    inc_pulse = 1'b0;
    cyc(1);
    check("inc_ignored", disp, 16'h0010);

    // 00:59 + 1 s carries into minutes; 59:59 + 1 s wraps.
    do_clear();
    set_secs(59);
    cyc(1);
    check("set_0059", disp, 16'h0059);
    enable = 1'b1;
    cyc(4);
    enable = 1'b0;
    cyc(1);
    check("carry_0100", disp, 16'h0100);
    set_secs(3539);
    cyc(1);
    check("set_5959", disp, 16'h5959);
    enable = 1'b1;
    cyc(4);
    enable = 1'b0;
    cyc(1);
    check("wrap_0000", disp, 16'h0000);

    // Countdown 00:03 -> 00:00 with flag on the zero edge.
    do_clear();
    set_secs(3);
    enable_decrement = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cyc(1);
      case (i)
        5:  check("dn_0002", disp, 16'h0002);
        9:  check("dn_0001", disp, 16'h0001);
        11: check("dn_flag_low", {15'd0, flag}, 16'h0);
        12: check("dn_flag_rise", {15'd0, flag}, 16'h1);
        13: check("dn_0000", disp, 16'h0000);
        default: ;
      endcase
    end
    enable_decrement = 1'b0;
    cyc(3);
    check("flag_sticky", {15'd0, flag}, 16'h1);
    do_clear();
    check("clear_flag", {15'd0, flag}, 16'h0);

    // Countdown at 00:00: flag next edge, no underflow.
    enable_decrement = 1'b1;
    cyc(1);
    check("zero_flag", {15'd0, flag}, 16'h1);
    cyc(8);
    check("zero_no_underflow", disp, 16'h0000);
    enable_decrement = 1'b0;
    do_clear();

    // Run to 00:07, write together with clear captures the pre-clear value.
    enable = 1'b1;
    cyc(28);
    enable = 1'b0;
    write = 1'b1;
    clear = 1'b1;
    cyc(1);
    write = 1'b0;
    clear = 1'b0;
    read = 1'b1;
    output_select = 2'b00;
    cyc(1);
    check("read_last_0007", disp, 16'h0007);
    read = 1'b0;
    output_select = 2'b01;
    cyc(1);
    check("count_cleared", disp, 16'h0000);
    set_secs(2);

    vecs[0] = '{1'b0, 2'b00, 16'h0000};
    vecs[1] = '{1'b0, 2'b01, 16'h0002};
    vecs[2] = '{1'b0, 2'b10, 16'h0007};
    vecs[3] = '{1'b0, 2'b11, 16'h0002};
    vecs[4] = '{1'b1, 2'b00, 16'h0007};
    vecs[5] = '{1'b1, 2'b01, 16'h0007};
    vecs[6] = '{1'b1, 2'b11, 16'h0007};
    for (int i = 0; i < 7; i++) begin
      read = vecs[i].rd;
      output_select = vecs[i].sel;
      cyc(1);
      check($sformatf("mux_%0d", i), disp, vecs[i].exp_disp);
    end
    read = 1'b0;
    output_select = 2'b01;

    // enable and enable_decrement together count up.
    enable = 1'b1;
    enable_decrement = 1'b1;
    cyc(4);
    enable = 1'b0;
    enable_decrement = 1'b0;
    cyc(1);
    check("both_count_up", disp, 16'h0003);

    // Asynchronous reset mid-countdown at 00:02 with the prescaler part-way.
    do_clear();
    set_secs(5);
    enable_decrement = 1'b1;
    cyc(14);
    check("pre_reset_0002", disp, 16'h0002);
    #2;
    nrst = 1'b0;
    #1;
    check("arst_disp", disp, 16'h0000);
    check("arst_flag", {15'd0, flag}, 16'h0);
    check("arst_tick", {15'd0, tick}, 16'h0);
    enable_decrement = 1'b0;
    enable = 1'b1;
    @(posedge clk);
    #1;
    nrst = 1'b1;
    first_tick = -1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      if (tick && first_tick < 0) first_tick = i;
    end
    check("post_reset_first_tick", 16'(first_tick), 16'd3);
    enable = 1'b0;
    cyc(1);
    check("post_reset_0001", disp, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
